// File: rtl/gate_trainer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_trainer_pkg
// Description : Shared encodings for the gate identifier: FSM states, the
//               eight trainer select codes and the seven truth-table
//               signatures, plus the truth-table decoder.
//               Truth tables are indexed tt[{b,a}], so tt[3] is a=1,b=1.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_trainer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_DECODE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Trainer select codes
    localparam logic [2:0] c_sel_and     = 3'b000;
    localparam logic [2:0] c_sel_or      = 3'b001;
    localparam logic [2:0] c_sel_not     = 3'b010;
    localparam logic [2:0] c_sel_nand    = 3'b011;
    localparam logic [2:0] c_sel_nor     = 3'b100;
    localparam logic [2:0] c_sel_xor     = 3'b101;
    localparam logic [2:0] c_sel_xnor    = 3'b110;
    localparam logic [2:0] c_sel_default = 3'b111;

    // Truth-table signatures, tt[3:0]
    localparam logic [3:0] c_tt_and  = 4'b1000;
    localparam logic [3:0] c_tt_or   = 4'b1110;
    localparam logic [3:0] c_tt_not  = 4'b0101;
    localparam logic [3:0] c_tt_nand = 4'b0111;
    localparam logic [3:0] c_tt_nor  = 4'b0001;
    localparam logic [3:0] c_tt_xor  = 4'b0110;
    localparam logic [3:0] c_tt_xnor = 4'b1001;

    // Returns {unknown, id_sel}; an all-zero table is the trainer's idle output.
    function automatic logic [3:0] decode_tt(input logic [3:0] tt);
        logic [3:0] w_res;
        case (tt)
            c_tt_and:  w_res = {1'b0, c_sel_and};
            c_tt_or:   w_res = {1'b0, c_sel_or};
            c_tt_not:  w_res = {1'b0, c_sel_not};
            c_tt_nand: w_res = {1'b0, c_sel_nand};
            c_tt_nor:  w_res = {1'b0, c_sel_nor};
            c_tt_xor:  w_res = {1'b0, c_sel_xor};
            c_tt_xnor: w_res = {1'b0, c_sel_xnor};
            4'b0000:   w_res = {1'b0, c_sel_default};
            default:   w_res = {1'b1, c_sel_default};
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_id_sync.sv
`default_nettype none
// ============================================================================
// Module      : gate_id_sync
// Description : Two-flop synchronizer, WIDTH bits wide, asynchronous
//               active-low reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_id_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Capture the asynchronous input and retime it through a second stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/tt_um_remya_gate_identifier.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_remya_gate_identifier
// Description : Drives all four input pairs into a gate trainer, samples its
//               output, and decodes the truth table into the trainer select
//               code. Optional macro GATE_ID_TT_EXPORT_EN exports the live
//               truth table on uio_out[3:0].
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_remya_gate_identifier
    import gate_trainer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_idx, w_idx_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_tt, w_tt_nxt;
    logic [2:0] r_id_sel, w_id_sel_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_unknown, w_unknown_nxt;
    logic       r_start_prev;

    logic [1:0] w_sync_q;
    logic       w_start_sync;
    logic       w_y_sync;
    logic       w_start_rise;
    logic       w_driving;
    logic       w_busy;
    logic       w_unused;

    assign w_unused = &{1'b0, uio_in, ui_in[7:2]};

    gate_id_sync #(
        .WIDTH (2)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (ui_in[1:0]),
        .o_q   (w_sync_q)
    );

    assign w_start_sync = w_sync_q[0];
    assign w_y_sync     = w_sync_q[1];
    assign w_start_rise = w_start_sync & ~r_start_prev;

    // Remember the previous synchronized start level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_prev <= 1'b0;
        end else begin
            r_start_prev <= w_start_sync;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'd0;
            r_cnt     <= 4'd0;
            r_tt      <= 4'd0;
            r_id_sel  <= 3'd0;
            r_valid   <= 1'b0;
            r_unknown <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tt      <= w_tt_nxt;
            r_id_sel  <= w_id_sel_nxt;
            r_valid   <= w_valid_nxt;
            r_unknown <= w_unknown_nxt;
        end
    end

    // Sweep sequencing: settle, sample, advance, then decode once all four pairs are in.
    // The y_obs synchronizer adds two cycles, so the settle time must cover it.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_tt_nxt      = r_tt;
        w_id_sel_nxt  = r_id_sel;
        w_valid_nxt   = r_valid;
        w_unknown_nxt = r_unknown;
        if (!ena) begin
            w_state_nxt   = ST_IDLE;
            w_valid_nxt   = 1'b0;
            w_unknown_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_rise) begin
                        w_state_nxt   = ST_DRIVE;
                        w_valid_nxt   = 1'b0;
                        w_unknown_nxt = 1'b0;
                        w_idx_nxt     = 2'd0;
                        w_cnt_nxt     = 4'd0;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == c_settle_last) begin
                        w_state_nxt = ST_SAMPLE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    w_tt_nxt[r_idx] = w_y_sync;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = ST_DECODE;
                    end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = ST_DRIVE;
                    end
                end
                ST_DECODE: begin
                    {w_unknown_nxt, w_id_sel_nxt} = decode_tt(r_tt);
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Inputs stay applied through SAMPLE so the sampled value matches the pair.
    assign w_driving = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
    assign w_busy    = w_driving || (r_state == ST_DECODE);

    assign uo_out = ena ? {w_busy, r_unknown, r_valid, r_id_sel,
                           w_driving & r_idx[1], w_driving & r_idx[0]}
                        : 8'h00;

`ifdef GATE_ID_TT_EXPORT_EN
    assign uio_out = {4'b0000, r_tt};
    assign uio_oe  = 8'h0F;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule
`default_nettype wire
